// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - fetch-side direct-mapped BTB predictor with decode-stage check
//
// Predicts at F from a direct-mapped BTB of 2-bit saturating counters, carries
// the prediction to D, compares it against the resolved branch there and raises
// a redirect on a mismatch, then trains the BTB entry once per resolved branch.
//
// Optional feature macro: BPRED_STATS_EN (adds stat_branches / stat_mispredicts).
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   pcF                   fetch PC
//   pred_taken_f          predicted direction for pcF (combinational)
//   pred_target_f         predicted next PC for pcF (combinational)
//   stallD, flushD        hold / invalidate the F->D prediction register
//   resolve_en_d          D holds a conditional branch
//   branch_taken_d        resolved direction from the decode compare
//   branch_target_d       resolved branch target
//   mispredict_d          prediction carried into D was wrong
//   correct_pc_d          redirect PC (0 when no branch is being checked)
//   stat_branches         [BPRED_STATS_EN] trained branches, wraps at 2**32
//   stat_mispredicts      [BPRED_STATS_EN] trained mispredicted branches, wraps

module branch_predictor #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pcF,
  output logic        pred_taken_f,
  output logic [31:0] pred_target_f,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        resolve_en_d,
  input  logic        branch_taken_d,
  input  logic [31:0] branch_target_d,
  output logic        mispredict_d,
  output logic [31:0] correct_pc_d
`ifdef BPRED_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int ENTRIES  = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [29:0]         tgt_q [ENTRIES];
  logic [1:0]          ctr_q [ENTRIES];

  // F-stage lookup
  logic [INDEX_BITS-1:0] idx_f;
  logic [TAG_BITS-1:0]   tag_f;
  logic                  hit_f;

  assign idx_f         = pcF[INDEX_BITS+1:2];
  assign tag_f         = pcF[31:INDEX_BITS+2];
  assign hit_f         = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign pred_taken_f  = hit_f && ctr_q[idx_f][1];
  assign pred_target_f = hit_f ? {tgt_q[idx_f], 2'b00} : pcF + 32'd4;

  // F->D prediction register; flush wins over stall
  logic        v_d;
  logic [31:0] pc_d;
  logic        pred_d;
  logic [31:0] ptgt_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v_d    <= 1'b0;
      pc_d   <= '0;
      pred_d <= 1'b0;
      ptgt_d <= '0;
    end else if (flushD) begin
      v_d    <= 1'b0;
      pc_d   <= '0;
      pred_d <= 1'b0;
      ptgt_d <= '0;
    end else if (!stallD) begin
      v_d    <= 1'b1;
      pc_d   <= pcF;
      pred_d <= pred_taken_f;
      ptgt_d <= pred_target_f;
    end
  end

  // D-stage check; a taken branch also mispredicts if the carried target is stale
  logic chk;
  logic train_en;

  assign chk          = resolve_en_d && v_d;
  assign mispredict_d = chk && ((pred_d != branch_taken_d) ||
                                (branch_taken_d && (ptgt_d != branch_target_d)));
  // Not-taken redirect skips the delay slot
  assign correct_pc_d = !chk          ? 32'd0 :
                        branch_taken_d ? branch_target_d : pc_d + 32'd8;

  // A stalled branch keeps re-checking but trains only on the release cycle
  assign train_en = chk && !stallD;

  logic [INDEX_BITS-1:0] idx_d;
  logic [TAG_BITS-1:0]   tag_d;
  logic                  hit_d;

  assign idx_d = pc_d[INDEX_BITS+1:2];
  assign tag_d = pc_d[31:INDEX_BITS+2];
  assign hit_d = valid_q[idx_d] && (tag_q[idx_d] == tag_d);

  // BTB write port; the F lookup above sees pre-write contents in the same cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else if (train_en) begin
      if (hit_d) begin
        if (branch_taken_d) begin
          if (ctr_q[idx_d] != 2'b11) ctr_q[idx_d] <= ctr_q[idx_d] + 2'd1;
          tgt_q[idx_d] <= branch_target_d[31:2];
        end else if (ctr_q[idx_d] != 2'b00) begin
          ctr_q[idx_d] <= ctr_q[idx_d] - 2'd1;
        end
      end else if (branch_taken_d) begin
        valid_q[idx_d] <= 1'b1;
        tag_q[idx_d]   <= tag_d;
        tgt_q[idx_d]   <= branch_target_d[31:2];
        ctr_q[idx_d]   <= 2'b10;
      end
    end
  end

`ifdef BPRED_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (train_en) begin
      stat_branches <= stat_branches + 32'd1;
      if (mispredict_d) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor

module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] pcF;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        stallD, flushD, resolve_en_d, branch_taken_d;
  logic [31:0] branch_target_d;
  logic        mispredict_d;
  logic [31:0] correct_pc_d;
`ifdef BPRED_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_predictor dut (
    .clk             (clk),
    .resetn          (resetn),
    .pcF             (pcF),
    .pred_taken_f    (pred_taken_f),
    .pred_target_f   (pred_target_f),
    .stallD          (stallD),
    .flushD          (flushD),
    .resolve_en_d    (resolve_en_d),
    .branch_taken_d  (branch_taken_d),
    .branch_target_d (branch_target_d),
    .mispredict_d    (mispredict_d),
    .correct_pc_d    (correct_pc_d)
`ifdef BPRED_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pt;
    logic [31:0] ptgt;
    logic        mis;
    logic [31:0] cpc;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model (16 entries)
  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  logic        m_vd, m_predd;
  logic [31:0] m_pcd, m_ptgtd, m_sb, m_sm;

  logic        obs_pt, obs_mis;
  logic [31:0] obs_ptgt, obs_cpc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_vd = 0; m_predd = 0; m_pcd = 0; m_ptgtd = 0; m_sb = 0; m_sm = 0;
  endtask

  function automatic logic m_hit(input logic [31:0] pc);
    return m_valid[pc[5:2]] && (m_tag[pc[5:2]] == pc[31:6]);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic chk;
    e.pt   = m_hit(pcF) && (m_ctr[pcF[5:2]] >= 2);
    e.ptgt = m_hit(pcF) ? m_tgt[pcF[5:2]] : pcF + 32'd4;
    chk    = resolve_en_d && m_vd;
    e.mis  = chk && ((m_predd != branch_taken_d) ||
                     (branch_taken_d && (m_ptgtd != branch_target_d)));
    e.cpc  = !chk ? 32'd0 : (branch_taken_d ? branch_target_d : m_pcd + 32'd8);
    e.sb   = m_sb;
    e.sm   = m_sm;
    return e;
  endfunction

  task automatic model_edge(input exp_t e);
    int i;
    if (!resetn) begin
      model_reset();
      return;
    end
    if (resolve_en_d && m_vd && !stallD) begin
      m_sb = m_sb + 1;
      if (e.mis) m_sm = m_sm + 1;
      i = m_pcd[5:2];
      if (m_hit(m_pcd)) begin
        if (branch_taken_d) begin
          if (m_ctr[i] < 3) m_ctr[i]++;
          m_tgt[i] = {branch_target_d[31:2], 2'b00};
        end else if (m_ctr[i] > 0) m_ctr[i]--;
      end else if (branch_taken_d) begin
        m_valid[i] = 1'b1; m_tag[i] = m_pcd[31:6];
        m_tgt[i] = {branch_target_d[31:2], 2'b00}; m_ctr[i] = 2;
      end
    end
    if (flushD) begin
      m_vd = 0; m_pcd = 0; m_predd = 0; m_ptgtd = 0;
    end else if (!stallD) begin
      m_vd = 1; m_pcd = pcF; m_predd = e.pt; m_ptgtd = e.ptgt;
    end
  endtask

  // Drive one cycle: push the model's expectation, compare at negedge, advance model
  task automatic cycle(input logic [31:0] pc, input logic st, input logic fl,
                       input logic re, input logic tk, input logic [31:0] tg);
    exp_t e, got_e;
    pcF = pc; stallD = st; flushD = fl; resolve_en_d = re;
    branch_taken_d = tk; branch_target_d = tg;
    e = model_out();
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      got_e = sb_q.pop_front();
      check("pred_taken_f", {31'd0, pred_taken_f}, {31'd0, got_e.pt});
      check("pred_target_f", pred_target_f, got_e.ptgt);
      check("mispredict_d", {31'd0, mispredict_d}, {31'd0, got_e.mis});
      check("correct_pc_d", correct_pc_d, got_e.cpc);
`ifdef BPRED_STATS_EN
      check("stat_branches", stat_branches, got_e.sb);
      check("stat_mispredicts", stat_mispredicts, got_e.sm);
`endif
    end
    obs_pt = pred_taken_f; obs_ptgt = pred_target_f;
    obs_mis = mispredict_d; obs_cpc = correct_pc_d;
    model_edge(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] BR  = 32'h0040_0010;
  localparam logic [31:0] AL  = 32'h0040_0050;
  localparam logic [31:0] T1  = 32'h0040_0100;
  localparam logic [31:0] T2  = 32'h0040_0200;

  initial begin
    resetn = 1'b0;
    model_reset();
    // reset state
    cycle(BR, 0, 0, 0, 0, 0);
    check("rst_pt", {31'd0, obs_pt}, 32'd0);
    check("rst_ptgt", obs_ptgt, 32'h0040_0014);
    check("rst_mis", {31'd0, obs_mis}, 32'd0);
    cycle(BR, 0, 0, 1, 1, T1);
    resetn = 1'b1;

    // first taken resolve allocates
    cycle(BR, 0, 0, 0, 0, 0);
    cycle(BR + 4, 0, 0, 1, 1, T1);
    check("s2_mis", {31'd0, obs_mis}, 32'd1);
    check("s2_cpc", obs_cpc, T1);
    cycle(BR, 0, 0, 0, 0, 0);
    check("s2_pt", {31'd0, obs_pt}, 32'd1);
    check("s2_ptgt", obs_ptgt, T1);

    // not-taken twice: 10 -> 01 -> 00
    cycle(BR + 4, 0, 0, 1, 0, 0);
    check("s3_mis1", {31'd0, obs_mis}, 32'd1);
    check("s3_cpc1", obs_cpc, 32'h0040_0018);
    cycle(BR, 0, 0, 0, 0, 0);
    cycle(BR + 4, 0, 0, 1, 0, 0);
    check("s3_mis2", {31'd0, obs_mis}, 32'd0);
`ifdef BPRED_STATS_EN
    cycle(BR + 8, 0, 0, 0, 0, 0);
    check("stat_br3", dut.stat_branches, 32'd3);
    check("stat_mp2", dut.stat_mispredicts, 32'd2);
`endif

    // alias replaces the entry
    cycle(AL, 0, 0, 0, 0, 0);
    cycle(AL + 4, 0, 0, 1, 1, T2);
    check("s4_mis", {31'd0, obs_mis}, 32'd1);
    cycle(BR, 0, 0, 0, 0, 0);
    check("s4_miss_pt", {31'd0, obs_pt}, 32'd0);
    check("s4_miss_ptgt", obs_ptgt, 32'h0040_0014);
    cycle(AL, 0, 0, 0, 0, 0);
    check("s4_al_pt", {31'd0, obs_pt}, 32'd1);
    check("s4_al_ptgt", obs_ptgt, T2);

    // stall: held redirect, single train on release
    for (int k = 0; k < 3; k++) begin
      cycle(AL + 4, 1, 0, 1, 0, 0);
      check("s5_stall_mis", {31'd0, obs_mis}, 32'd1);
    end
    cycle(AL, 0, 0, 1, 0, 0);
    check("s5_rel_mis", {31'd0, obs_mis}, 32'd1);
    cycle(AL + 4, 0, 0, 1, 1, T2);
    check("s5_tk_mis", {31'd0, obs_mis}, 32'd0);
    cycle(AL, 0, 0, 0, 0, 0);
    check("s5_once_pt", {31'd0, obs_pt}, 32'd1);

    // flush with a branch resolving
    cycle(AL + 4, 0, 1, 1, 0, 0);
    cycle(AL + 8, 0, 0, 1, 1, 32'h1234_5678);
    check("s5_flush_mis", {31'd0, obs_mis}, 32'd0);
    check("s5_flush_cpc", obs_cpc, 32'd0);

    // pcD + 8 and pcF + 4 wrap
    cycle(32'hFFFF_FFF8, 0, 0, 0, 0, 0);
    cycle(32'hFFFF_FFFC, 0, 0, 1, 0, 0);
    check("wrap_cpc", obs_cpc, 32'd0);
    check("wrap_ptgt", obs_ptgt, 32'd0);

    // asynchronous reset mid-operation
    cycle(AL, 0, 0, 0, 0, 0);
    pcF = AL; resolve_en_d = 1'b1; branch_taken_d = 1'b1; branch_target_d = 32'h0000_0040;
    stallD = 1'b0; flushD = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("arst_mis", {31'd0, mispredict_d}, 32'd0);
    check("arst_pt", {31'd0, pred_taken_f}, 32'd0);
    check("arst_ptgt", pred_target_f, AL + 32'd4);
    model_reset();
    cycle(AL, 0, 0, 1, 1, T1);
    resetn = 1'b1;
    cycle(AL, 0, 0, 1, 1, T1);
    check("arst_post_mis", {31'd0, obs_mis}, 32'd0);

    // random traffic over aliasing PCs
    for (int n = 0; n < 200; n++) begin
      logic [31:0] pcs [4];
      logic [31:0] tgs [3];
      pcs[0] = BR; pcs[1] = AL; pcs[2] = 32'h0040_0090; pcs[3] = 32'h0040_0024;
      tgs[0] = T1; tgs[1] = T2; tgs[2] = 32'h0040_0300;
      cycle(pcs[$urandom_range(3)], ($urandom_range(4) == 0), ($urandom_range(9) == 0),
            ($urandom_range(4) != 0), $urandom_range(1), tgs[$urandom_range(2)]);
    end

    check("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
